mem32_word_reader: RTL and testbench
====================================

// Module: mem32_word_reader
// PURPOSE
//  Read-side counterpart of the 32-bit-over-8-bit memory path: accepts one 32-bit word read request,
//  issues four sequential byte reads to a byte-wide memory port, reassembles the bytes into a word
//  and presents it on dataout with a one-cycle valid pulse. Sits between a 32-bit consumer and the
//  byte memory that the 32-bit write packer fills.
// PARAMETERS
//  BYTE_ADDR_W  6  byte address width of the memory; word address width = BYTE_ADDR_W-2
//  MEM_LAT      1  byte read latency in cycles from mem_rd strobe to mem_rdata sample (legal 1..3)
//  BIG_ENDIAN   0  0: byte at offset 0 -> dataout[7:0]; 1: byte at offset 0 -> dataout[31:24]
// PORTS
//  clk        in   1              clock, all state on rising edge
//  rst        in   1              asynchronous reset, active-low
//  rd_req     in   1              word read request; accepted when rd_req && rd_ready at clk edge
//  rd_addr    in   BYTE_ADDR_W-2  word address, sampled only at acceptance
//  rd_ready   out  1              block idle / able to accept a request
//  busy       out  1              ~rd_ready
//  mem_rd     out  1              byte read strobe to memory
//  mem_addr   out  BYTE_ADDR_W    byte address = {word_addr, offset[1:0]}
//  mem_rdata  in   8              byte read data, sampled MEM_LAT cycles after its strobe
//  dataout    out  32             assembled word; holds last completed value
//  valid      out  1              one-cycle pulse, dataout updated in same cycle
// BEHAVIOUR
//  - Reset (rst=0, async): state IDLE, rd_ready=1, busy=0, mem_rd=0, mem_addr=0, dataout=0, valid=0,
//    issue/capture counters=0, partial-word register=0.
//  - FSM: IDLE -> ISSUE on accept; ISSUE (4 cycles, offset 0..3) -> DRAIN when offset 3 issued;
//    DRAIN -> IDLE when byte 3 captured. Capture runs as pipelined counter in parallel with ISSUE.
//  - Timing (edge E0 = accepting edge): mem_rd=1 with offset k between Ek and Ek+1, k=0..3; byte k
//    sampled at edge E(k+1+MEM_LAT); at E(4+MEM_LAT) dataout<=assembled word incl. byte 3,
//    valid=1 for the cycle E(4+MEM_LAT)..E(5+MEM_LAT). Request-to-valid latency 4+MEM_LAT cycles
//    (5 at default).
//  - rd_ready=0 from E0 until the valid cycle; rd_ready=1 during the valid cycle, so a new request
//    may be accepted at the edge ending the valid cycle (back-to-back throughput 5+MEM_LAT cycles).
//  - rd_req while busy: ignored, not queued, no effect on in-flight read or rd_addr latch.
//  - mem_rd=0 and mem_addr holds last value outside ISSUE; exactly four strobes per request.
//  - mem_rdata ignored except at the four scheduled capture edges.
//  - Top word address (all ones): bytes {max,0}..{max,3}; no carry into higher bits, no wrap to 0.
//  - Assembly: offset k -> dataout[8k+7:8k] (BIG_ENDIAN=0) or dataout[31-8k:24-8k] (BIG_ENDIAN=1).
//  - Reset mid-operation: transaction aborted, no valid pulse, dataout=0, returns to IDLE.
//  - valid never asserted twice for one request; dataout changes only on valid cycles or reset.
// TESTING
//  1 Memory bytes 0..3 = 60,AF,2D,30; rd_req, rd_addr=0 -> mem_addr 0,1,2,3 on 4 consecutive
//    cycles, valid 5 cycles after accept, dataout=32'h302DAF60.
//  2 Bytes 4..7 = D2,05,5E,73; request word 1 accepted in valid cycle of word 0 read ->
//    back-to-back, second valid 6 cycles after first, dataout=32'h735E05D2.
//  3 rd_req held high with rd_addr toggling while busy -> only first address read, one valid per
//    accepted request, strobe count exactly 4 per request.
//  4 rst=0 asserted two cycles after accept, released later -> no valid, dataout=0, rd_ready=1,
//    then a fresh read of word 0 returns 32'h302DAF60.
//  5 MEM_LAT=2, BIG_ENDIAN=1, word 0 as in test 1 -> valid 6 cycles after accept,
//    dataout=32'h60AF2D30.
//  6 Word address 15 (BYTE_ADDR_W=6), bytes 60..63 = 11,22,33,44 -> mem_addr 60..63,
//    dataout=32'h44332211.

Source files
------------

// File: rtl/mem32_word_reader.sv
// Reads one 32-bit word as four sequential byte reads from a byte-wide memory port and
// reassembles it; byte captures run as a latency pipeline alongside the issue phase.
module mem32_word_reader #(
    parameter int unsigned BYTE_ADDR_W = 6,
    parameter int unsigned MEM_LAT     = 1,
    parameter int unsigned BIG_ENDIAN  = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rd_req,
    input  logic [BYTE_ADDR_W-3:0] rd_addr,
    output logic                   rd_ready,
    output logic                   busy,
    output logic                   mem_rd,
    output logic [BYTE_ADDR_W-1:0] mem_addr,
    input  logic [7:0]             mem_rdata,
    output logic [31:0]            dataout,
    output logic                   valid
);

    typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

    state_e                 state_q, state_d;
    logic [BYTE_ADDR_W-3:0] waddr_q, waddr_d;
    logic [1:0]             iss_q, iss_d;
    logic [1:0]             cap_q, cap_d;
    logic [MEM_LAT-1:0]     pipe_q, pipe_d;
    logic [31:0]            part_q, part_d;
    logic [31:0]            data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   capture;
    logic [1:0]             slot;

    assign rd_ready = (state_q == StIdle);
    assign busy     = ~rd_ready;
    assign mem_rd   = (state_q == StIssue);
    // iss_q stays at 3 after the last strobe so mem_addr holds its final value while idle.
    assign mem_addr = {waddr_q, iss_q};
    assign dataout  = data_q;
    assign valid    = valid_q;
    assign capture  = pipe_q[MEM_LAT-1];
    assign slot     = (BIG_ENDIAN != 0) ? (2'd3 - cap_q) : cap_q;

    always_comb begin
        state_d = state_q;
        waddr_d = waddr_q;
        iss_d   = iss_q;
        cap_d   = cap_q;
        part_d  = part_q;
        data_d  = data_q;
        valid_d = 1'b0;

        // Strobe history: bit i set means a strobe issued i+1 cycles ago.
        pipe_d[0] = mem_rd;
        for (int i = 1; i < int'(MEM_LAT); i++) begin
            pipe_d[i] = pipe_q[i-1];
        end

        if (capture) begin
            part_d[{slot, 3'b000} +: 8] = mem_rdata;
            cap_d = cap_q + 2'd1;
            if (cap_q == 2'd3) begin
                data_d  = part_d;
                valid_d = 1'b1;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (rd_req) begin
                    waddr_d = rd_addr;
                    iss_d   = 2'd0;
                    cap_d   = 2'd0;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (iss_q == 2'd3) begin
                    state_d = StDrain;
                end else begin
                    iss_d = iss_q + 2'd1;
                end
            end
            StDrain: begin
                if (capture && (cap_q == 2'd3)) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            waddr_q <= '0;
            iss_q   <= '0;
            cap_q   <= '0;
            pipe_q  <= '0;
            part_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            waddr_q <= waddr_d;
            iss_q   <= iss_d;
            cap_q   <= cap_d;
            pipe_q  <= pipe_d;
            part_q  <= part_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: tb/tb_mem32_word_reader.sv
// Directed bench for mem32_word_reader: default instance plus a MEM_LAT=2 big-endian instance,
// each fed by a behavioural byte memory with matching read latency.
module tb_mem32_word_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rd_req = 1'b0, rd_req2 = 1'b0;
    logic [3:0]  rd_addr = '0, rd_addr2 = '0;
    logic        rd_ready, busy, mem_rd, valid;
    logic        rd_ready2, busy2, mem_rd2, valid2;
    logic [5:0]  mem_addr, mem_addr2;
    logic [7:0]  rdata1 = 8'hEE, rdata2 = 8'hEE, m2a = 8'hEE;
    logic [31:0] dataout, dataout2;
    logic [7:0]  mem [64];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem32_word_reader dut (
        .clk(clk), .rst(rst), .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready),
        .busy(busy), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(rdata1),
        .dataout(dataout), .valid(valid)
    );

    mem32_word_reader #(.BYTE_ADDR_W(6), .MEM_LAT(2), .BIG_ENDIAN(1)) dut2 (
        .clk(clk), .rst(rst), .rd_req(rd_req2), .rd_addr(rd_addr2), .rd_ready(rd_ready2),
        .busy(busy2), .mem_rd(mem_rd2), .mem_addr(mem_addr2), .mem_rdata(rdata2),
        .dataout(dataout2), .valid(valid2)
    );

    // Garbage (EE) is presented whenever no read is scheduled.
    always @(posedge clk) begin
        rdata1 <= mem_rd ? mem[mem_addr] : 8'hEE;
        m2a    <= mem_rd2 ? mem[mem_addr2] : 8'hEE;
        rdata2 <= m2a;
    end

    // Caller is at posedge+1 with the selected DUT idle; returns at posedge+1 after the valid cycle.
    task automatic do_read(input bit sel, input logic [3:0] addr, output int lat,
                           output logic [31:0] d, output int nstb, output logic [23:0] adrs);
        lat = -1; d = '0; nstb = 0; adrs = '0;
        if (sel) begin rd_req2 = 1'b1; rd_addr2 = addr; end
        else begin rd_req = 1'b1; rd_addr = addr; end
        @(posedge clk); #1;
        rd_req = 1'b0; rd_req2 = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (sel ? mem_rd2 : mem_rd) begin
                if (nstb < 4) adrs[6*nstb +: 6] = sel ? mem_addr2 : mem_addr;
                nstb++;
            end
            if (sel ? valid2 : valid) begin
                lat = n;
                d = sel ? dataout2 : dataout;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (rd_ready !== 1'b1) begin errors++; $display("FAIL reset_rd_ready got %b exp 1", rd_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL reset_mem_rd got %b exp 0", mem_rd); end
        checks++; if (mem_addr !== 6'd0) begin errors++; $display("FAIL reset_mem_addr got %h exp 0", mem_addr); end
        checks++; if (dataout !== 32'h0) begin errors++; $display("FAIL reset_dataout got %h exp 0", dataout); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid); end
        checks++; if (rd_ready2 !== 1'b1) begin errors++; $display("FAIL reset_rd_ready2 got %b exp 1", rd_ready2); end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        int lat, nstb;
        logic [31:0] d;
        logic [23:0] a;
        do_read(1'b0, 4'd0, lat, d, nstb, a);
        checks++; if (lat != 5) begin errors++; $display("FAIL single_latency got %0d exp 5", lat); end
        checks++; if (d !== 32'h302DAF60) begin errors++; $display("FAIL single_data got %h exp 302daf60", d); end
        checks++; if (nstb != 4) begin errors++; $display("FAIL single_strobes got %0d exp 4", nstb); end
        checks++; if (a !== {6'd3, 6'd2, 6'd1, 6'd0}) begin errors++; $display("FAIL single_addrs got %h exp %h", a, {6'd3, 6'd2, 6'd1, 6'd0}); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL single_valid_pulse got %b exp 0", valid); end
        checks++; if (dataout !== 32'h302DAF60) begin errors++; $display("FAIL single_hold got %h exp 302daf60", dataout); end
        checks++; if (mem_addr !== 6'd3) begin errors++; $display("FAIL single_addr_hold got %0d exp 3", mem_addr); end
        checks++; if (rd_ready !== 1'b1) begin errors++; $display("FAIL single_ready_after got %b exp 1", rd_ready); end
    endtask

    task automatic test_back_to_back();
        int n1 = -1, n2 = -1;
        logic [31:0] d1 = '0, d2 = '0;
        logic rdy = 1'b0, bsy;
        rd_req = 1'b1; rd_addr = 4'd0;
        @(posedge clk); #1;
        rd_req = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (valid) begin
                n1 = n; d1 = dataout; rdy = rd_ready;
                rd_req = 1'b1; rd_addr = 4'd1;
                break;
            end
        end
        @(posedge clk); #1;
        rd_req = 1'b0;
        bsy = busy;
        for (int m = 0; m < 20; m++) begin
            @(negedge clk);
            if (valid) begin n2 = m + 1; d2 = dataout; break; end
        end
        @(posedge clk); #1;
        checks++; if (n1 != 5) begin errors++; $display("FAIL b2b_first_latency got %0d exp 5", n1); end
        checks++; if (d1 !== 32'h302DAF60) begin errors++; $display("FAIL b2b_first_data got %h exp 302daf60", d1); end
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL b2b_ready_in_valid got %b exp 1", rdy); end
        checks++; if (bsy !== 1'b1) begin errors++; $display("FAIL b2b_accepted got busy %b exp 1", bsy); end
        checks++; if (n2 != 6) begin errors++; $display("FAIL b2b_spacing got %0d exp 6", n2); end
        checks++; if (d2 !== 32'h735E05D2) begin errors++; $display("FAIL b2b_second_data got %h exp 735e05d2", d2); end
    endtask

    task automatic test_busy_ignore();
        int nstb = 0, nval = 0;
        logic [23:0] a = '0;
        logic [31:0] d = '0;
        rd_req = 1'b1; rd_addr = 4'd2;
        @(posedge clk);
        for (int n = 0; n < 14; n++) begin
            @(negedge clk);
            if (mem_rd) begin
                if (nstb < 4) a[6*nstb +: 6] = mem_addr;
                nstb++;
            end
            if (valid) begin
                nval++; d = dataout; rd_req = 1'b0;
            end else if (rd_req) begin
                rd_addr = (n % 2 == 1) ? 4'd3 : 4'd1;
            end
        end
        @(posedge clk); #1;
        checks++; if (nstb != 4) begin errors++; $display("FAIL busy_strobes got %0d exp 4", nstb); end
        checks++; if (nval != 1) begin errors++; $display("FAIL busy_valids got %0d exp 1", nval); end
        checks++; if (a !== {6'd11, 6'd10, 6'd9, 6'd8}) begin errors++; $display("FAIL busy_addrs got %h exp %h", a, {6'd11, 6'd10, 6'd9, 6'd8}); end
        checks++; if (d !== 32'h04030201) begin errors++; $display("FAIL busy_data got %h exp 04030201", d); end
    endtask

    task automatic test_reset_abort();
        int nval = 0, lat, nstb;
        logic [31:0] d;
        logic [23:0] a;
        rd_req = 1'b1; rd_addr = 4'd1;
        @(posedge clk); #1;
        rd_req = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL abort_valid got %b exp 0", valid); end
        checks++; if (dataout !== 32'h0) begin errors++; $display("FAIL abort_dataout got %h exp 0", dataout); end
        checks++; if (rd_ready !== 1'b1) begin errors++; $display("FAIL abort_ready got %b exp 1", rd_ready); end
        checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL abort_mem_rd got %b exp 0", mem_rd); end
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (valid) nval++;
        end
        @(posedge clk); #1;
        checks++; if (nval != 0) begin errors++; $display("FAIL abort_no_valid got %0d exp 0", nval); end
        do_read(1'b0, 4'd0, lat, d, nstb, a);
        checks++; if (d !== 32'h302DAF60) begin errors++; $display("FAIL abort_fresh_data got %h exp 302daf60", d); end
        checks++; if (lat != 5) begin errors++; $display("FAIL abort_fresh_latency got %0d exp 5", lat); end
    endtask

    task automatic test_lat2_big_endian();
        int lat, nstb;
        logic [31:0] d;
        logic [23:0] a;
        do_read(1'b1, 4'd0, lat, d, nstb, a);
        checks++; if (lat != 6) begin errors++; $display("FAIL lat2_latency got %0d exp 6", lat); end
        checks++; if (d !== 32'h60AF2D30) begin errors++; $display("FAIL lat2_data got %h exp 60af2d30", d); end
        checks++; if (nstb != 4) begin errors++; $display("FAIL lat2_strobes got %0d exp 4", nstb); end
        checks++; if (a !== {6'd3, 6'd2, 6'd1, 6'd0}) begin errors++; $display("FAIL lat2_addrs got %h exp %h", a, {6'd3, 6'd2, 6'd1, 6'd0}); end
    endtask

    task automatic test_top_word();
        int lat, nstb;
        logic [31:0] d;
        logic [23:0] a;
        do_read(1'b0, 4'd15, lat, d, nstb, a);
        checks++; if (a !== {6'd63, 6'd62, 6'd61, 6'd60}) begin errors++; $display("FAIL top_addrs got %h exp %h", a, {6'd63, 6'd62, 6'd61, 6'd60}); end
        checks++; if (d !== 32'h44332211) begin errors++; $display("FAIL top_data got %h exp 44332211", d); end
        checks++; if (lat != 5) begin errors++; $display("FAIL top_latency got %0d exp 5", lat); end
        checks++; if (mem_addr !== 6'd63) begin errors++; $display("FAIL top_addr_hold got %0d exp 63", mem_addr); end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 8'hA5;
        mem[0]  = 8'h60; mem[1]  = 8'hAF; mem[2]  = 8'h2D; mem[3]  = 8'h30;
        mem[4]  = 8'hD2; mem[5]  = 8'h05; mem[6]  = 8'h5E; mem[7]  = 8'h73;
        mem[8]  = 8'h01; mem[9]  = 8'h02; mem[10] = 8'h03; mem[11] = 8'h04;
        mem[60] = 8'h11; mem[61] = 8'h22; mem[62] = 8'h33; mem[63] = 8'h44;
        test_reset();
        test_single();
        test_back_to_back();
        test_busy_ignore();
        test_reset_abort();
        test_lat2_big_endian();
        test_top_word();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
